sma_pulse_out: RTL and testbench

SMA_PULSE_OUT -- requirements
Module: sma_pulse_out

---
 rtl/sma_out_pkg.sv | 26 ++
 rtl/sma_out_timer.sv | 85 ++++++++
 rtl/sma_pulse_out.sv | 203 ++++++++++++++++++++
 tb/tb_sma_pulse_out.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sma_out_pkg.sv
// Shared register map, CTRL/STATUS bit positions and FSM state encoding for the SMA pulse generator.
package sma_out_pkg;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_CTRL   = 3'd1;
    localparam logic [2:0] ADDR_PERIOD = 3'd2;
    localparam logic [2:0] ADDR_HIGH   = 3'd3;
    localparam logic [2:0] ADDR_COUNT  = 3'd4;
    localparam logic [2:0] ADDR_STATUS = 3'd5;

    localparam int CTRL_START  = 0;
    localparam int CTRL_CONT   = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_INVERT = 3;
    localparam int CTRL_STOP   = 4;

    localparam int STAT_DONE = 0;
    localparam int STAT_BUSY = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HIGH_PH = 2'd1,
        LOW_PH  = 2'd2
    } state_t;

endpackage

// File: rtl/sma_out_timer.sv
// Phase and pulse counters with period/high shadows; flags phase_end and train_end to the FSM.
// Loads take effect on the edge they are requested; phase_end/train_end are pure decodes of registers.
module sma_out_timer #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_busy,
    input  logic                 i_start,
    input  logic                 i_restart,
    input  logic                 i_load_high,
    input  logic                 i_load_low,
    input  logic                 i_dec_pulse,
    input  logic [CNT_WIDTH-1:0] i_period,
    input  logic [CNT_WIDTH-1:0] i_high,
    input  logic [CNT_WIDTH-1:0] i_count,
    output logic                 o_phase_end,
    output logic                 o_train_end,
    output logic                 o_cur_low_zero,
    output logic                 o_new_high_zero
);

    logic [CNT_WIDTH-1:0] r_sh_period;
    logic [CNT_WIDTH-1:0] r_sh_high;
    logic [CNT_WIDTH-1:0] r_phase_cnt;
    logic [CNT_WIDTH-1:0] r_pulse_cnt;

    logic [CNT_WIDTH-1:0] w_cur_per;
    logic [CNT_WIDTH-1:0] w_cur_high;
    logic [CNT_WIDTH-1:0] w_cur_low;
    logic [CNT_WIDTH-1:0] w_new_per;
    logic [CNT_WIDTH-1:0] w_new_high;
    logic [CNT_WIDTH-1:0] w_new_low;
    logic                 w_use_new;

    function automatic logic [CNT_WIDTH-1:0] eff_period(input logic [CNT_WIDTH-1:0] per);
        return (per < CNT_WIDTH'(2)) ? CNT_WIDTH'(2) : per;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] eff_high(input logic [CNT_WIDTH-1:0] per,
                                                      input logic [CNT_WIDTH-1:0] hi);
        return (hi > per) ? per : hi;
    endfunction

    // "cur" lengths come from the shadows; "new" lengths from the live registers being latched.
    assign w_cur_per  = eff_period(r_sh_period);
    assign w_cur_high = eff_high(w_cur_per, r_sh_high);
    assign w_cur_low  = w_cur_per - w_cur_high;
    assign w_new_per  = eff_period(i_period);
    assign w_new_high = eff_high(w_new_per, i_high);
    assign w_new_low  = w_new_per - w_new_high;
    assign w_use_new  = i_start | i_restart;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sh_period <= '0;
            r_sh_high   <= '0;
            r_phase_cnt <= '0;
            r_pulse_cnt <= '0;
        end else begin
            if (w_use_new) begin
                r_sh_period <= i_period;
                r_sh_high   <= i_high;
            end
            if (i_start) begin
                r_pulse_cnt <= i_count;
            end else if (i_dec_pulse && (r_pulse_cnt != '0)) begin
                r_pulse_cnt <= r_pulse_cnt - CNT_WIDTH'(1);
            end
            if (i_load_high) begin
                r_phase_cnt <= w_use_new ? w_new_high : w_cur_high;
            end else if (i_load_low) begin
                r_phase_cnt <= w_use_new ? w_new_low : w_cur_low;
            end else if (i_busy && (r_phase_cnt != '0)) begin
                r_phase_cnt <= r_phase_cnt - CNT_WIDTH'(1);
            end
        end
    end

    assign o_phase_end     = (r_phase_cnt <= CNT_WIDTH'(1));
    assign o_train_end     = (r_pulse_cnt <= CNT_WIDTH'(1));
    assign o_cur_low_zero  = (w_cur_low == '0);
    assign o_new_high_zero = (w_new_high == '0);

endmodule

// File: rtl/sma_pulse_out.sv
// Avalon-MM programmable pulse-train generator driving one SMA output with a done interrupt.
// Reads have one-cycle latency; writes are always accepted (no wait states, no backpressure).
module sma_pulse_out
    import sma_out_pkg::*;
#(
    parameter int   CNT_WIDTH   = 32,
    parameter logic RESET_LEVEL = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        out_port,
    output logic        irq
);

    state_t               r_state;
    logic                 r_level;
    logic                 r_cont;
    logic                 r_irq_en;
    logic                 r_invert;
    logic [CNT_WIDTH-1:0] r_period;
    logic [CNT_WIDTH-1:0] r_high;
    logic [CNT_WIDTH-1:0] r_count;
    logic                 r_done;
    logic [31:0]          r_readdata;
    logic                 r_out;

    logic                 w_wr;
    logic                 w_wr_data;
    logic                 w_wr_ctrl;
    logic                 w_wr_status;
    logic                 w_start;
    logic                 w_stop;
    logic                 w_cont_eff;
    logic                 w_level_nxt;
    logic                 w_invert_nxt;
    logic [CNT_WIDTH-1:0] w_wr_val;
    logic [31:0]          w_rd;

    state_t               w_state_nxt;
    logic                 w_tm_start;
    logic                 w_tm_restart;
    logic                 w_load_high;
    logic                 w_load_low;
    logic                 w_dec_pulse;
    logic                 w_set_done;
    logic                 w_phase_end;
    logic                 w_train_end;
    logic                 w_cur_low_zero;
    logic                 w_new_high_zero;

    assign w_wr         = chipselect & ~write_n;
    assign w_wr_data    = w_wr && (address == ADDR_DATA);
    assign w_wr_ctrl    = w_wr && (address == ADDR_CTRL);
    assign w_wr_status  = w_wr && (address == ADDR_STATUS);
    assign w_start      = w_wr_ctrl & writedata[CTRL_START];
    assign w_stop       = w_wr_ctrl & writedata[CTRL_STOP];
    assign w_wr_val     = CNT_WIDTH'(writedata);
    // A CTRL write carrying START also sets the mode that START runs in.
    assign w_cont_eff   = w_wr_ctrl ? writedata[CTRL_CONT] : r_cont;
    assign w_level_nxt  = w_wr_data ? writedata[0] : r_level;
    assign w_invert_nxt = w_wr_ctrl ? writedata[CTRL_INVERT] : r_invert;

    sma_out_timer #(
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timer (
        .clk             (clk),
        .reset           (reset),
        .i_busy          (r_state != IDLE),
        .i_start         (w_tm_start),
        .i_restart       (w_tm_restart),
        .i_load_high     (w_load_high),
        .i_load_low      (w_load_low),
        .i_dec_pulse     (w_dec_pulse),
        .i_period        (r_period),
        .i_high          (r_high),
        .i_count         (r_count),
        .o_phase_end     (w_phase_end),
        .o_train_end     (w_train_end),
        .o_cur_low_zero  (w_cur_low_zero),
        .o_new_high_zero (w_new_high_zero)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_tm_start   = 1'b0;
        w_tm_restart = 1'b0;
        w_load_high  = 1'b0;
        w_load_low   = 1'b0;
        w_dec_pulse  = 1'b0;
        w_set_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start && !w_stop) begin
                    if ((r_count == '0) && !w_cont_eff) begin
                        w_set_done = 1'b1;
                    end else begin
                        w_tm_start = 1'b1;
                        if (w_new_high_zero) begin
                            w_state_nxt = LOW_PH;
                            w_load_low  = 1'b1;
                        end else begin
                            w_state_nxt = HIGH_PH;
                            w_load_high = 1'b1;
                        end
                    end
                end
            end
            HIGH_PH, LOW_PH: begin
                if (w_stop) begin
                    w_state_nxt = IDLE;
                end else if (w_phase_end) begin
                    if ((r_state == HIGH_PH) && !w_cur_low_zero) begin
                        w_state_nxt = LOW_PH;
                        w_load_low  = 1'b1;
                    end else begin
                        // Period boundary: count down, then finish or re-latch and go again.
                        w_dec_pulse = !w_cont_eff;
                        if (!w_cont_eff && w_train_end) begin
                            w_state_nxt = IDLE;
                            w_set_done  = 1'b1;
                        end else begin
                            w_tm_restart = 1'b1;
                            if (w_new_high_zero) begin
                                w_state_nxt = LOW_PH;
                                w_load_low  = 1'b1;
                            end else begin
                                w_state_nxt = HIGH_PH;
                                w_load_high = 1'b1;
                            end
                        end
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_rd = '0;
        case (address)
            ADDR_DATA:   w_rd[0] = r_level;
            ADDR_CTRL: begin
                w_rd[CTRL_CONT]   = r_cont;
                w_rd[CTRL_IRQ_EN] = r_irq_en;
                w_rd[CTRL_INVERT] = r_invert;
            end
            ADDR_PERIOD: w_rd = 32'(r_period);
            ADDR_HIGH:   w_rd = 32'(r_high);
            ADDR_COUNT:  w_rd = 32'(r_count);
            ADDR_STATUS: begin
                w_rd[STAT_DONE] = r_done;
                w_rd[STAT_BUSY] = (r_state != IDLE);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_level    <= RESET_LEVEL;
            r_cont     <= 1'b0;
            r_irq_en   <= 1'b0;
            r_invert   <= 1'b0;
            r_period   <= '0;
            r_high     <= '0;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_readdata <= '0;
            r_out      <= RESET_LEVEL;
        end else begin
            r_state    <= w_state_nxt;
            r_level    <= w_level_nxt;
            r_invert   <= w_invert_nxt;
            r_readdata <= w_rd;
            if (w_wr_ctrl) begin
                r_cont   <= writedata[CTRL_CONT];
                r_irq_en <= writedata[CTRL_IRQ_EN];
            end
            if (w_wr && (address == ADDR_PERIOD)) r_period <= w_wr_val;
            if (w_wr && (address == ADDR_HIGH))   r_high   <= w_wr_val;
            if (w_wr && (address == ADDR_COUNT))  r_count  <= w_wr_val;
            if (w_set_done) begin
                r_done <= 1'b1;
            end else if (w_wr_status && writedata[STAT_DONE]) begin
                r_done <= 1'b0;
            end
            // Output follows the state being entered so it never lags the FSM.
            r_out <= (w_state_nxt == IDLE) ? w_level_nxt
                                           : ((w_state_nxt == HIGH_PH) ^ w_invert_nxt);
        end
    end

    assign readdata = r_readdata;
    assign out_port = r_out;
    assign irq      = r_done & r_irq_en;

endmodule

// File: tb/tb_sma_pulse_out.sv
// Randomized and directed bench for sma_pulse_out against a waveform-queue reference model.
`timescale 1ns/1ps
module tb_sma_pulse_out;

    localparam logic       RL       = 1'b1;
    localparam logic [2:0] A_DATA   = 3'd0;
    localparam logic [2:0] A_CTRL   = 3'd1;
    localparam logic [2:0] A_PERIOD = 3'd2;
    localparam logic [2:0] A_HIGH   = 3'd3;
    localparam logic [2:0] A_COUNT  = 3'd4;
    localparam logic [2:0] A_STATUS = 3'd5;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        out_port;
    logic        irq;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    sma_pulse_out #(.CNT_WIDTH(32), .RESET_LEVEL(RL)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        @(negedge clk);
        d = readdata;
    endtask

    // One period of the reference waveform: max(p,2) cycles, the first min(h,period) high.
    function automatic void push_period(input int p, input int h, input bit inv);
        int pe;
        int he;
        pe = (p < 2) ? 2 : p;
        he = (h > pe) ? pe : h;
        for (int i = 0; i < pe; i++) exp_q.push_back(bit'(i < he) ^ inv);
    endfunction

    function automatic void push_level(input int n, input bit lvl);
        for (int i = 0; i < n; i++) exp_q.push_back(lvl);
    endfunction

    task automatic check_wave(input string name, input int mid_idx,
                              input logic [2:0] mid_a, input logic [31:0] mid_d);
        int   bad;
        logic got;
        bit   want;
        bad = -1; got = 1'b0; want = 1'b0;
        for (int j = 0; j < exp_q.size(); j++) begin
            if (bad < 0 && out_port !== exp_q[j]) begin
                bad = j; got = out_port; want = exp_q[j];
            end
            if (j == mid_idx) begin
                address = mid_a; writedata = mid_d; chipselect = 1'b1; write_n = 1'b0;
            end else if (j == mid_idx + 1) begin
                chipselect = 1'b0; write_n = 1'b1;
            end
            @(negedge clk);
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: out_port at cycle %0d = %b, expected %b", name, bad, got, want);
        end
        exp_q.delete();
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = A_DATA; writedata = '0;
        #12;
        checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL reset_readdata: got %h expected 0", readdata); end
        checks++; if (out_port !== RL) begin errors++; $display("FAIL reset_out: got %b expected %b", out_port, RL); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        @(negedge clk);
        reset = 1'b0;
        bus_read(A_DATA, rd);
        checks++; if (rd !== {31'd0, RL}) begin errors++; $display("FAIL reset_data: got %h expected %h", rd, {31'd0, RL}); end
        bus_read(A_STATUS, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_status: got %h expected 0", rd); end
        bus_read(A_PERIOD, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL reset_period: got %h expected 0", rd); end
    endtask

    task automatic test_regs;
        logic [31:0] rd;
        logic [31:0] vp, vh, vc;
        vp = $urandom; vh = $urandom; vc = $urandom;
        bus_write(A_PERIOD, vp);
        bus_write(A_HIGH, vh);
        bus_write(A_COUNT, vc);
        bus_read(A_PERIOD, rd);
        checks++; if (rd !== vp) begin errors++; $display("FAIL rb_period: got %h expected %h", rd, vp); end
        bus_read(A_HIGH, rd);
        checks++; if (rd !== vh) begin errors++; $display("FAIL rb_high: got %h expected %h", rd, vh); end
        bus_read(A_COUNT, rd);
        checks++; if (rd !== vc) begin errors++; $display("FAIL rb_count: got %h expected %h", rd, vc); end
        bus_write(A_CTRL, 32'hFFFF_FFEE);
        bus_read(A_CTRL, rd);
        checks++; if (rd !== 32'h0000_000E) begin errors++; $display("FAIL rb_ctrl: got %h expected 0000000e", rd); end
        for (int a = 6; a < 8; a++) begin
            bus_read(3'(a), rd);
            checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rb_unmapped%0d: got %h expected 0", a, rd); end
        end
        bus_write(A_DATA, 32'hFFFF_FFFE);
        bus_read(A_DATA, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL rb_data: got %h expected 0", rd); end
        checks++; if (out_port !== 1'b0) begin errors++; $display("FAIL data_out: got %b expected 0", out_port); end
        bus_write(A_CTRL, 32'd0);
    endtask

    task automatic test_pulse_train;
        logic [31:0] rd;
        bus_write(A_DATA, 32'd1);
        bus_write(A_PERIOD, 32'd10);
        bus_write(A_HIGH, 32'd3);
        bus_write(A_COUNT, 32'd2);
        bus_write(A_CTRL, 32'h4);
        bus_write(A_CTRL, 32'h5);
        push_period(10, 3, 1'b0); push_period(10, 3, 1'b0); push_level(3, 1'b1);
        check_wave("train_10_3_x2", -1, A_DATA, 32'd0);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL train_irq: got %b expected 1", irq); end
        bus_read(A_STATUS, rd);
        checks++; if (rd !== 32'd1) begin errors++; $display("FAIL train_status: got %h expected 1", rd); end
        bus_write(A_STATUS, 32'd1);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL train_irq_clr: got %b expected 0", irq); end
        bus_read(A_STATUS, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL train_status_clr: got %h expected 0", rd); end
    endtask

    task automatic test_cont_stop;
        logic [31:0] rd;
        bus_write(A_DATA, 32'd0);
        bus_write(A_PERIOD, 32'd1);
        bus_write(A_HIGH, 32'd5);
        bus_write(A_CTRL, 32'h2);
        bus_write(A_CTRL, 32'h3);
        push_level(20, 1'b1);
        check_wave("cont_const_high", -1, A_DATA, 32'd0);
        bus_read(A_STATUS, rd);
        checks++; if (rd !== 32'd2) begin errors++; $display("FAIL cont_busy: got %h expected 2", rd); end
        bus_write(A_CTRL, 32'h12);
        checks++; if (out_port !== 1'b0) begin errors++; $display("FAIL stop_out: got %b expected 0", out_port); end
        bus_read(A_STATUS, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL stop_status: got %h expected 0", rd); end
        bus_write(A_CTRL, 32'h13);
        bus_read(A_STATUS, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL stop_wins: got %h expected 0", rd); end
        bus_write(A_CTRL, 32'd0);
    endtask

    task automatic test_count_zero;
        logic [31:0] rd;
        bus_write(A_DATA, 32'd0);
        bus_write(A_PERIOD, 32'd6);
        bus_write(A_HIGH, 32'd3);
        bus_write(A_COUNT, 32'd0);
        bus_write(A_CTRL, 32'h1);
        bus_read(A_STATUS, rd);
        checks++; if (rd !== 32'd1) begin errors++; $display("FAIL cnt0_done: got %h expected 1", rd); end
        push_level(8, 1'b0);
        check_wave("cnt0_no_pulse", -1, A_DATA, 32'd0);
        bus_write(A_STATUS, 32'd1);
    endtask

    task automatic test_high_update;
        bus_write(A_DATA, 32'd1);
        bus_write(A_PERIOD, 32'd8);
        bus_write(A_HIGH, 32'd2);
        bus_write(A_COUNT, 32'd2);
        bus_write(A_CTRL, 32'h1);
        push_period(8, 2, 1'b0); push_period(8, 4, 1'b0); push_level(3, 1'b1);
        check_wave("high_update", 3, A_HIGH, 32'd4);
        bus_write(A_STATUS, 32'd1);
    endtask

    task automatic test_busy_start_ignored;
        bus_write(A_DATA, 32'd1);
        bus_write(A_PERIOD, 32'd4);
        bus_write(A_HIGH, 32'd2);
        bus_write(A_COUNT, 32'd1);
        bus_write(A_CTRL, 32'h1);
        push_period(4, 2, 1'b0); push_level(4, 1'b1);
        check_wave("start_while_busy", 1, A_CTRL, 32'h1);
        bus_write(A_STATUS, 32'd1);
    endtask

    task automatic test_done_priority;
        logic [31:0] rd;
        bus_write(A_PERIOD, 32'd2);
        bus_write(A_HIGH, 32'd1);
        bus_write(A_COUNT, 32'd1);
        bus_write(A_CTRL, 32'h1);
        @(negedge clk);
        bus_write(A_STATUS, 32'd1);
        bus_read(A_STATUS, rd);
        checks++; if (rd !== 32'd1) begin errors++; $display("FAIL done_priority: got %h expected 1", rd); end
        bus_write(A_STATUS, 32'd1);
        bus_read(A_STATUS, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL done_w1c: got %h expected 0", rd); end
    endtask

    task automatic test_random;
        logic [31:0] rd;
        int p, h, c;
        bit inv, lvl, ien;
        for (int it = 0; it < 8; it++) begin
            p = $urandom_range(0, 12); h = $urandom_range(0, 14); c = $urandom_range(1, 3);
            inv = 1'($urandom_range(0, 1)); lvl = 1'($urandom_range(0, 1)); ien = 1'($urandom_range(0, 1));
            bus_write(A_DATA, {31'd0, lvl});
            bus_write(A_PERIOD, 32'(p));
            bus_write(A_HIGH, 32'(h));
            bus_write(A_COUNT, 32'(c));
            bus_write(A_CTRL, {28'd0, inv, ien, 2'b00});
            bus_write(A_CTRL, {28'd0, inv, ien, 2'b01});
            for (int k = 0; k < c; k++) push_period(p, h, inv);
            push_level(3, lvl);
            check_wave($sformatf("rand%0d_p%0d_h%0d_c%0d_i%0d", it, p, h, c, inv), -1, A_DATA, 32'd0);
            checks++; if (irq !== ien) begin errors++; $display("FAIL rand%0d_irq: got %b expected %b", it, irq, ien); end
            bus_read(A_STATUS, rd);
            checks++; if (rd !== 32'd1) begin errors++; $display("FAIL rand%0d_status: got %h expected 1", it, rd); end
            bus_write(A_STATUS, 32'd1);
        end
        bus_write(A_CTRL, 32'd0);
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        bus_write(A_DATA, 32'd0);
        bus_write(A_PERIOD, 32'd10);
        bus_write(A_HIGH, 32'd5);
        bus_write(A_COUNT, 32'd3);
        bus_write(A_CTRL, 32'h8);
        bus_write(A_CTRL, 32'h9);
        @(negedge clk);
        checks++; if (out_port !== 1'b0) begin errors++; $display("FAIL mid_high_inv: got %b expected 0", out_port); end
        #2 reset = 1'b1;
        #1;
        checks++; if (out_port !== RL) begin errors++; $display("FAIL mid_reset_out: got %b expected %b", out_port, RL); end
        checks++; if (readdata !== 32'd0) begin errors++; $display("FAIL mid_reset_rd: got %h expected 0", readdata); end
        @(negedge clk);
        reset = 1'b0;
        push_level(25, RL);
        check_wave("post_reset_idle", -1, A_DATA, 32'd0);
        bus_read(A_STATUS, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL post_reset_status: got %h expected 0", rd); end
        bus_read(A_CTRL, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL post_reset_ctrl: got %h expected 0", rd); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_pulse_train();
        test_cont_stop();
        test_count_zero();
        test_high_update();
        test_busy_start_ignored();
        test_done_priority();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
